// File: rtl/snake_tile_render.sv
// -----------------------------------------------------------------------------
// snake_tile_render
//
// Renders a snake playfield as 8-bit RRRGGGBB video. The board is a grid of
// COLS x ROWS tiles, each TILE_PX pixels square, stored as 2-bit codes
// (0 empty, 1 body, 2 head, 3 food) in a tile RAM. The game logic writes the
// RAM through a simple write port; the video side reads it every pixel.
// A clear sweep (clr_req) zeroes every tile, one per clock.
//
// Pipeline (pixel coordinate presented at cycle n, colour at cycle n+2):
//   stage 1: tile address / on-board flag / syncs / valid registered
//   stage 2: RAM output register / syncs / valid registered
//
// Ports
//   clk                 pixel clock, rising edge
//   rst                 asynchronous reset, active low
//   pixel_x, pixel_y    pixel coordinate, already advanced 2 clk
//   valid               active-video flag
//   hsync_in, vsync_in  active-low syncs from the timing generator
//   wr_en/wr_addr/wr_data  tile write port (ignored while busy)
//   clr_req             single-cycle request to clear the board
//   busy                clear sweep in progress
//   rgb                 RRRGGGBB colour, 0 outside active video
//   de                  data enable (valid delayed 2)
//   hsync_out, vsync_out  syncs delayed 2
//
// Build option
//   SNAKE_GRID_EN       when defined, empty tiles draw a grid line (8'h49) on
//                       their first pixel column and first pixel row.
// -----------------------------------------------------------------------------
module snake_tile_render #(
    parameter int TILE_PX = 20,
    parameter int COLS    = 40,
    parameter int ROWS    = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        valid,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_en,
    input  logic [10:0] wr_addr,
    input  logic [1:0]  wr_data,
    input  logic        clr_req,
    output logic        busy,
    output logic [7:0]  rgb,
    output logic        de,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam int TILES = COLS * ROWS;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state;
    logic [10:0] clr_addr;

    logic [1:0]  ram [0:TILES-1];

    // Tile coordinate of the incoming pixel.
    logic [9:0]  tile_x;
    logic [9:0]  tile_y;
    logic        in_board;
    logic [10:0] rd_addr;

    assign tile_x   = pixel_x / 10'(TILE_PX);
    assign tile_y   = pixel_y / 10'(TILE_PX);
    assign in_board = (tile_x < 10'(COLS)) && (tile_y < 10'(ROWS));
    // Only meaningful when in_board; off-board pixels never reach the RAM.
    assign rd_addr  = 11'(tile_y) * 11'(COLS) + 11'(tile_x);

    // Stage registers
    logic [10:0] addr_q;
    logic        board_q;
    logic        valid_q;
    logic        hsync_q;
    logic        vsync_q;
    logic [1:0]  tile_q;

    // Frame counter for the food blink
    logic        vsync_prev;
    logic [7:0]  frame_cnt;
    logic        blink;

    assign blink = frame_cnt[4];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others regardless of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            board_q   <= 1'b0;
            valid_q   <= 1'b0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            tile_q    <= 2'd0;
            de        <= 1'b0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            addr_q    <= in_board ? rd_addr : 11'd0;
            board_q   <= in_board;
            valid_q   <= valid;
            hsync_q   <= hsync_in;
            vsync_q   <= vsync_in;
            // Off-board tiles read as empty without touching the RAM.
            tile_q    <= board_q ? ram[addr_q] : 2'd0;
            de        <= valid_q;
            hsync_out <= hsync_q;
            vsync_out <= vsync_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_prev <= 1'b1;
            frame_cnt  <= 8'd0;
        end else begin
            vsync_prev <= vsync_in;
            if (vsync_prev && !vsync_in)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Clear FSM: one tile per cycle from address 0 to TILES-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            clr_addr <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_addr == 11'(TILES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 11'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-port arbitration: the sweep owns the port while clearing.
    logic        ram_we;
    logic [10:0] ram_waddr;
    logic [1:0]  ram_wdata;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = 2'd0;
        end else if (wr_en && ({1'b0, wr_addr} < 12'(TILES))) begin
            ram_we = 1'b1;
        end
    end

    // NOTE: the tile RAM has no reset; contents are only defined after a clear
    // sweep, which keeps it mappable onto block RAM. A read and write of the
    // same address on one edge return the old data to the read register.
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdata;
    end

`ifdef SNAKE_GRID_EN
    logic on_grid;
    logic grid_q1;
    logic grid_q2;

    assign on_grid = ((pixel_x % 10'(TILE_PX)) == 10'd0) ||
                     ((pixel_y % 10'(TILE_PX)) == 10'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grid_q1 <= 1'b0;
            grid_q2 <= 1'b0;
        end else begin
            grid_q1 <= on_grid;
            grid_q2 <= grid_q1;
        end
    end
`endif

    // Colour lookup on the registered tile code; blanked outside active video.
    always_comb begin
        rgb = 8'h00;
        if (de) begin
            case (tile_q)
                2'd1:    rgb = 8'h1C;
                2'd2:    rgb = 8'hFC;
                2'd3:    rgb = blink ? 8'hE0 : 8'h00;
                default: rgb = 8'h00;
            endcase
`ifdef SNAKE_GRID_EN
            if (tile_q == 2'd0 && grid_q2)
                rgb = 8'h49;
`endif
        end
    end

endmodule

// File: tb/tb_snake_tile_render.sv
// -----------------------------------------------------------------------------
// tb_snake_tile_render
//
// Self-checking bench for snake_tile_render. Each stimulus item drives one
// clock of inputs; the expected {rgb, de, hsync_out, vsync_out} for that item
// is computed from a tile/frame model and pushed to a queue, then popped and
// compared two cycles later when the DUT produces it.
//
// Model timing: the read for the item at cycle n happens on the edge that
// commits the write of item n+1, so an item's expectation includes its own
// write but not the next one's.
// -----------------------------------------------------------------------------
module tb_snake_tile_render;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        valid;
    logic        hsync_in;
    logic        vsync_in;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [1:0]  wr_data;
    logic        clr_req;
    logic        busy;
    logic [7:0]  rgb;
    logic        de;
    logic        hsync_out;
    logic        vsync_out;

    always #10 clk = ~clk;

    snake_tile_render dut (
        .clk       (clk),
        .rst       (rst),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .valid     (valid),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .busy      (busy),
        .rgb       (rgb),
        .de        (de),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        v;
        logic        hs;
        logic        vs;
        logic        we;
        logic [10:0] wa;
        logic [1:0]  wd;
    } item_t;

    logic [10:0] exp_q [$];        // {rgb, de, hs, vs}
    logic [1:0]  mram [0:1199];
    int          fc;
    logic        vs_prev;
    int          total = 0;
    int          bad   = 0;

    function automatic item_t idle();
        item_t t;
        t.x = 10'd0; t.y = 10'd0; t.v = 1'b0; t.hs = 1'b1; t.vs = 1'b1;
        t.we = 1'b0; t.wa = 11'd0; t.wd = 2'd0;
        return t;
    endfunction

    function automatic item_t pix(input int x, input int y, input logic v = 1'b1);
        item_t t = idle();
        t.x = 10'(x); t.y = 10'(y); t.v = v;
        return t;
    endfunction

    function automatic item_t wr(input int a, input int d);
        item_t t = idle();
        t.we = 1'b1; t.wa = 11'(a); t.wd = 2'(d);
        return t;
    endfunction

    function automatic item_t vs_low();
        item_t t = idle();
        t.vs = 1'b0;
        return t;
    endfunction

    function automatic logic [7:0] colour(input int x, input int y);
        int tx = x / 20;
        int ty = y / 20;
        logic [1:0] t;
        logic [7:0] fc8 = 8'(fc);
        if (tx >= 40 || ty >= 30) t = 2'd0;
        else                      t = mram[ty * 40 + tx];
`ifdef SNAKE_GRID_EN
        if (t == 2'd0 && (x % 20 == 0 || y % 20 == 0)) return 8'h49;
`endif
        case (t)
            2'd1:    return 8'h1C;
            2'd2:    return 8'hFC;
            2'd3:    return fc8[4] ? 8'hE0 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic apply(input item_t it);
        pixel_x  = it.x;  pixel_y = it.y;  valid = it.v;
        hsync_in = it.hs; vsync_in = it.vs;
        wr_en    = it.we; wr_addr = it.wa; wr_data = it.wd;
        if (vs_prev && !it.vs) fc = (fc + 1) % 256;
        vs_prev = it.vs;
        if (it.we && it.wa < 11'd1200) mram[it.wa] = it.wd;
        exp_q.push_back({it.v ? colour(int'(it.x), int'(it.y)) : 8'h00, it.v, it.hs, it.vs});
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clr_req = 1'b1;
        @(posedge clk); #1 clr_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pixel_x = 10'd25; pixel_y = 10'd22; valid = 1'b1;
        hsync_in = 1'b0; vsync_in = 1'b0;
        wr_en = 1'b0; wr_addr = 11'd0; wr_data = 2'd0; clr_req = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rgb !== 8'h00)     begin bad++; $display("FAIL reset_rgb got=%h want=00", rgb); end
        total++; if (de !== 1'b0)       begin bad++; $display("FAIL reset_de got=%b want=0", de); end
        total++; if (hsync_out !== 1'b1) begin bad++; $display("FAIL reset_hsync got=%b want=1", hsync_out); end
        total++; if (vsync_out !== 1'b1) begin bad++; $display("FAIL reset_vsync got=%b want=1", vsync_out); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        exp_q.delete();
        apply(idle());
        fc = 0; vs_prev = 1'b1;
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy); end
        total++; if (de !== 1'b0)   begin bad++; $display("FAIL post_reset_de got=%b want=0", de); end
    endtask

    task automatic test_clear();
        item_t s [$];
        logic [10:0] got, e;
        int cnt;
        bit done;
        s = '{wr(0, 1), wr(5, 2), wr(41, 3), wr(1199, 1), idle()};
        exp_q.delete();
        for (int i = 0; i < s.size() + 2; i++) begin
            @(posedge clk); #1;
            apply(i < s.size() ? s[i] : idle());
            @(negedge clk);
            if (i >= 2) begin
                got = {rgb, de, hsync_out, vsync_out}; e = exp_q.pop_front(); total++;
                if (got !== e) begin bad++; $display("FAIL clear_setup[%0d] got=%h want=%h", i - 2, got, e); end
            end
        end
        pulse_clear();
        cnt = 0; done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy_start got=%b want=1", busy); end
            end
            if (busy === 1'b1) cnt++; else done = 1;
            @(posedge clk); #1;
            // Mid-sweep write and a second request must both be ignored.
            if (cnt == 600) begin wr_en = 1'b1; wr_addr = 11'd41; wr_data = 2'd1; clr_req = 1'b1; end
            else            begin wr_en = 1'b0; clr_req = 1'b0; end
        end
        wr_en = 1'b0; clr_req = 1'b0;
        total++; if (cnt != 1200) begin bad++; $display("FAIL clear_busy_cycles got=%0d want=1200", cnt); end
        for (int i = 0; i < 1200; i++) mram[i] = 2'd0;
        s.delete();
        for (int i = 0; i < 1200; i++) s.push_back(pix((i % 40) * 20 + (i % 20), (i / 40) * 20 + (i % 7)));
        exp_q.delete();
        for (int i = 0; i < s.size() + 2; i++) begin
            @(posedge clk); #1;
            apply(i < s.size() ? s[i] : idle());
            @(negedge clk);
            if (i >= 2) begin
                got = {rgb, de, hsync_out, vsync_out}; e = exp_q.pop_front(); total++;
                if (got !== e) begin bad++; $display("FAIL clear_sweep tile %0d got=%h want=%h", i - 2, got, e); end
            end
        end
    endtask

    task automatic test_reset_abort();
        item_t s [$];
        logic [10:0] got, e;
        exp_q.delete();
        apply(wr(1000, 1));
        @(posedge clk); #1 apply(idle());
        pulse_clear();
        repeat (100) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_in_reset got=%b want=0", busy); end
        fc = 0; vs_prev = 1'b1;
        @(negedge clk); rst = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_after got=%b want=0", busy); end
        s = '{pix(5, 505), pix(799, 599), pix(105, 0)};
        exp_q.delete();
        for (int i = 0; i < s.size() + 2; i++) begin
            @(posedge clk); #1;
            apply(i < s.size() ? s[i] : idle());
            @(negedge clk);
            if (i >= 2) begin
                got = {rgb, de, hsync_out, vsync_out}; e = exp_q.pop_front(); total++;
                if (got !== e) begin bad++; $display("FAIL abort_read[%0d] got=%h want=%h", i - 2, got, e); end
            end
        end
    endtask

    task automatic test_head_and_bounds();
        item_t s [$];
        logic [10:0] got, e;
        s = '{wr(41, 2), wr(40, 1), wr(1199, 2), wr(42, 0), idle(),
              pix(25, 22), pix(20, 20), pix(39, 39), pix(40, 20), pix(0, 20),
              pix(800, 0), pix(799, 599), pix(0, 600), pix(1023, 1023), pix(19, 39)};
        exp_q.delete();
        for (int i = 0; i < s.size() + 2; i++) begin
            @(posedge clk); #1;
            apply(i < s.size() ? s[i] : idle());
            @(negedge clk);
            if (i >= 2) begin
                got = {rgb, de, hsync_out, vsync_out}; e = exp_q.pop_front(); total++;
                if (got !== e) begin bad++; $display("FAIL head_bounds[%0d] got=%h want=%h", i - 2, got, e); end
            end
        end
    endtask

    task automatic test_blink();
        item_t s [$];
        logic [10:0] got, e;
        int n = (15 - fc + 256) % 256;
        s = '{wr(0, 3), idle(), idle()};
        for (int k = 0; k < n; k++) begin s.push_back(vs_low()); s.push_back(idle()); end
        s.push_back(idle()); s.push_back(pix(0, 0)); s.push_back(pix(10, 10));       // frame 15
        s.push_back(idle()); s.push_back(idle());
        s.push_back(vs_low()); s.push_back(idle()); s.push_back(idle());
        s.push_back(pix(0, 0));                                                      // frame 16
        s.push_back(idle()); s.push_back(idle());
        for (int k = 0; k < 239; k++) begin s.push_back(vs_low()); s.push_back(idle()); end
        s.push_back(idle()); s.push_back(pix(5, 5));                                 // frame 255
        s.push_back(idle()); s.push_back(idle());
        s.push_back(vs_low()); s.push_back(idle()); s.push_back(idle());
        s.push_back(pix(0, 0));                                                      // frame 0
        exp_q.delete();
        for (int i = 0; i < s.size() + 2; i++) begin
            @(posedge clk); #1;
            apply(i < s.size() ? s[i] : idle());
            @(negedge clk);
            if (i >= 2) begin
                got = {rgb, de, hsync_out, vsync_out}; e = exp_q.pop_front(); total++;
                if (got !== e) begin bad++; $display("FAIL blink[%0d] got=%h want=%h", i - 2, got, e); end
            end
        end
    endtask

    task automatic test_sync();
        item_t s [$];
        item_t t;
        logic [10:0] got, e;
        s = '{wr(100, 1), idle(), pix(400, 40), pix(400, 40, 1'b0)};
        t = pix(400, 40, 1'b0); t.hs = 1'b0; s.push_back(t); s.push_back(t); s.push_back(t);
        t = pix(405, 45);       t.hs = 1'b0; s.push_back(t);
        s.push_back(pix(410, 50));
        t = pix(410, 50);       t.vs = 1'b0; s.push_back(t); s.push_back(t);
        s.push_back(idle());
        exp_q.delete();
        for (int i = 0; i < s.size() + 2; i++) begin
            @(posedge clk); #1;
            apply(i < s.size() ? s[i] : idle());
            @(negedge clk);
            if (i >= 2) begin
                got = {rgb, de, hsync_out, vsync_out}; e = exp_q.pop_front(); total++;
                if (got !== e) begin bad++; $display("FAIL sync[%0d] got=%h want=%h", i - 2, got, e); end
            end
        end
    endtask

    task automatic test_write_rules();
        item_t s [$];
        item_t t;
        logic [10:0] got, e;
        s = '{wr(1199, 1), wr(5, 1), idle(), wr(1200, 3), wr(2047, 3), idle(),
              pix(799, 599), pix(0, 0), pix(100, 0)};
        t = pix(100, 0); t.we = 1'b1; t.wa = 11'd5; t.wd = 2'd2; s.push_back(t);
        s.push_back(pix(100, 0));
        exp_q.delete();
        for (int i = 0; i < s.size() + 2; i++) begin
            @(posedge clk); #1;
            apply(i < s.size() ? s[i] : idle());
            @(negedge clk);
            if (i >= 2) begin
                got = {rgb, de, hsync_out, vsync_out}; e = exp_q.pop_front(); total++;
                if (got !== e) begin bad++; $display("FAIL write_rules[%0d] got=%h want=%h", i - 2, got, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        item_t s [$];
        item_t t;
        logic [10:0] got, e;
        for (int i = 0; i < 80; i++) begin
            t = pix(int'($urandom_range(0, 850)), int'($urandom_range(0, 650)), 1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 2) == 0) begin
                t.we = 1'b1; t.wa = 11'($urandom_range(0, 1299)); t.wd = 2'($urandom_range(0, 3));
            end
            s.push_back(t);
        end
        exp_q.delete();
        for (int i = 0; i < s.size() + 2; i++) begin
            @(posedge clk); #1;
            apply(i < s.size() ? s[i] : idle());
            @(negedge clk);
            if (i >= 2) begin
                got = {rgb, de, hsync_out, vsync_out}; e = exp_q.pop_front(); total++;
                if (got !== e) begin bad++; $display("FAIL back_to_back[%0d] got=%h want=%h", i - 2, got, e); end
            end
        end
    endtask

`ifdef SNAKE_GRID_EN
    task automatic test_grid();
        item_t s [$];
        logic [10:0] got, e;
        s = '{wr(1, 0), wr(2, 1), idle(), pix(20, 7), pix(21, 7), pix(25, 20), pix(40, 0)};
        exp_q.delete();
        for (int i = 0; i < s.size() + 2; i++) begin
            @(posedge clk); #1;
            apply(i < s.size() ? s[i] : idle());
            @(negedge clk);
            if (i >= 2) begin
                got = {rgb, de, hsync_out, vsync_out}; e = exp_q.pop_front(); total++;
                if (got !== e) begin bad++; $display("FAIL grid[%0d] got=%h want=%h", i - 2, got, e); end
            end
        end
    endtask
`endif

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fc = 0; vs_prev = 1'b1;
        test_reset();
        test_clear();
        test_reset_abort();
        test_head_and_bounds();
        test_blink();
        test_sync();
        test_write_rules();
        test_back_to_back();
`ifdef SNAKE_GRID_EN
        test_grid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
